fetch_unit: RTL and testbench

//  - Instruction-fetch stage feeding the decode/controller stage of the single-cycle RISC-V CPU.
//  - Owns the PC, issues one instruction-memory request at a time and holds the returned word until the core accepts it.
//  - Computes the next PC from the core's redirect (PCSrc, Jalr, target).
//  - The held instr[6:0], [14:12] and [30] drive the controller's op, funct3 and funct7b5 inputs.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_unit_pc_next_sel.sv | 27 ++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V fetch stage.
package riscv_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam int unsigned ILEN         = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC mux for the fetch stage: sequential pc+4, branch/jump target, or JALR target
// with bit0 cleared; also flags a word-misaligned result.
module pc_next_sel
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic            redirect_jalr,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] next_pc_c,
    output logic            misalign_c
);

    always_comb begin
        next_pc_c = pc + XLEN'(4);
        if (redirect_valid) begin
            next_pc_c = redirect_target;
            if (redirect_jalr) begin
                next_pc_c[0] = 1'b0;
            end
        end
        misalign_c = |next_pc_c[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and holds the
// returned word until the core retires it. Optional feature: FETCH_MISALIGN_CHK_EN.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic            redirect_jalr,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fetch_fault
);

`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    // Without the checker the low address bits are simply dropped.
    localparam logic [XLEN-1:0] ADDR_MASK = CHK_EN ? {XLEN{1'b1}} : {{(XLEN-2){1'b1}}, 2'b00};

    fetch_state_t    state;
    logic [XLEN-1:0] next_pc;
    logic            misalign;

    pc_next_sel #(
        .XLEN(XLEN)
    ) u_pc_next_sel (
        .pc             (imem_addr),
        .redirect_valid (redirect_valid),
        .redirect_jalr  (redirect_jalr),
        .redirect_target(redirect_target),
        .next_pc_c      (next_pc),
        .misalign_c     (misalign)
    );

    assign instr_pc_plus4 = instr_pc + XLEN'(4);

    // imem_addr doubles as the PC register; it only moves on retire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            imem_req_valid <= 1'b0;
            imem_addr      <= RESET_PC;
            instr_valid    <= 1'b0;
            instr          <= NOP_INSTR;
            instr_pc       <= RESET_PC;
            fetch_fault    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state       <= HOLD;
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (CHK_EN && misalign) begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                        end else begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                            imem_addr      <= next_pc & ADDR_MASK;
                        end
                    end
                end
                FAULT: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default build and FETCH_MISALIGN_CHK_EN).
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_ready;
    logic        redirect_valid;
    logic        redirect_jalr;
    logic [31:0] redirect_target;
    logic        fetch_fault;

    int n_vec;
    int n_err;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_jalr  (redirect_jalr),
        .redirect_target(redirect_target),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory side of one fetch: wait for a request, accept it, answer one cycle later.
    task automatic do_fetch(input logic [31:0] rdata, output logic [31:0] addr, output bit ok);
        ok   = 1'b0;
        addr = 32'hxxxx_xxxx;
        for (int i = 0; i < 20 && imem_req_valid !== 1'b1; i++) step();
        if (imem_req_valid !== 1'b1) return;
        addr           = imem_addr;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata     = rdata;
        step();
        imem_rsp_valid = 1'b0;
        ok             = (instr_valid === 1'b1);
    endtask

    task automatic retire(input logic rv, input logic jalr, input logic [31:0] tgt);
        instr_ready     = 1'b1;
        redirect_valid  = rv;
        redirect_jalr   = jalr;
        redirect_target = tgt;
        step();
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_jalr   = 1'b0;
        redirect_target = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        n_vec++;
        if ({imem_req_valid, instr_valid, fetch_fault} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000", {imem_req_valid, instr_valid, fetch_fault});
        end
        n_vec++;
        if (instr !== 32'h0000_0013 || imem_addr !== 32'h0 || instr_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_regs: instr %h addr %h pc %h want 00000013/0/0", instr, imem_addr, instr_pc);
        end
        reset = 1'b1;
    endtask

    task automatic test_first_fetch();
        logic [31:0] a;
        bit ok;
        do_fetch(32'h0050_0093, a, ok);
        n_vec++;
        if (!ok || a !== 32'h0) begin
            n_err++;
            $display("FAIL first_fetch: ok %0d addr %h want 1/00000000", ok, a);
        end
        n_vec++;
        if (instr !== 32'h0050_0093 || instr_pc !== 32'h0 || instr_pc_plus4 !== 32'h4) begin
            n_err++;
            $display("FAIL first_hold: instr %h pc %h pc4 %h want 00500093/0/4", instr, instr_pc, instr_pc_plus4);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        bit ok;
        retire(1'b0, 1'b0, 32'h0);
        n_vec++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL retire_drop: instr_valid got %b want 0", instr_valid);
        end
        do_fetch(32'h0010_0113, a, ok);
        n_vec++;
        if (!ok || a !== 32'h4) begin
            n_err++;
            $display("FAIL seq_addr1: ok %0d addr %h want 1/00000004", ok, a);
        end
        retire(1'b0, 1'b0, 32'h0);
        do_fetch(32'h0020_0193, a, ok);
        n_vec++;
        if (!ok || a !== 32'h8 || instr_pc !== 32'h8 || instr_pc_plus4 !== 32'hC) begin
            n_err++;
            $display("FAIL seq_addr2: ok %0d addr %h pc %h pc4 %h want 1/8/8/c", ok, a, instr_pc, instr_pc_plus4);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] a;
        bit ok;
        retire(1'b1, 1'b0, 32'h40);
        do_fetch(32'h0000_0067, a, ok);
        n_vec++;
        if (!ok || a !== 32'h40) begin
            n_err++;
            $display("FAIL redirect: ok %0d addr %h want 1/00000040", ok, a);
        end
        retire(1'b1, 1'b1, 32'h41);
        do_fetch(32'h0000_80E7, a, ok);
        n_vec++;
        if (!ok || a !== 32'h40 || instr !== 32'h0000_80E7) begin
            n_err++;
            $display("FAIL jalr_mask: ok %0d addr %h instr %h want 1/00000040/000080e7", ok, a, instr);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        bit ok;
        imem_req_ready = 1'b0;
        retire(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            imem_rsp_valid = (i == 2);
            imem_rdata     = 32'hDEAD_BEEF;
            step();
            n_vec++;
            if (imem_req_valid !== 1'b1 || imem_addr !== 32'h44) begin
                n_err++;
                $display("FAIL stall_%0d: req %b addr %h want 1/00000044", i, imem_req_valid, imem_addr);
            end
        end
        imem_rsp_valid = 1'b0;
        n_vec++;
        if (instr !== 32'h0000_80E7 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_in_req: instr %h valid %b want 000080e7/0", instr, instr_valid);
        end
        do_fetch(32'h0010_0113, a, ok);
        n_vec++;
        if (!ok || a !== 32'h44) begin
            n_err++;
            $display("FAIL after_stall: ok %0d addr %h want 1/00000044", ok, a);
        end
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        n_vec++;
        if (instr !== 32'h0010_0113 || instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_in_hold: instr %h valid %b req %b want 00100113/1/0", instr, instr_valid, imem_req_valid);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] a;
        bit ok;
        retire(1'b1, 1'b0, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0013, a, ok);
        n_vec++;
        if (!ok || a !== 32'hFFFF_FFFC || instr_pc_plus4 !== 32'h0) begin
            n_err++;
            $display("FAIL top_addr: ok %0d addr %h pc4 %h want 1/fffffffc/0", ok, a, instr_pc_plus4);
        end
        retire(1'b0, 1'b0, 32'h0);
        do_fetch(32'h0000_0013, a, ok);
        n_vec++;
        if (!ok || a !== 32'h0) begin
            n_err++;
            $display("FAIL wrap: ok %0d addr %h want 1/00000000", ok, a);
        end
        retire(1'b0, 1'b0, 32'h0);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({imem_req_valid, instr_valid, fetch_fault} !== 3'b000 || imem_addr !== 32'h0 ||
            instr !== 32'h0000_0013 || instr_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_in_wait: req %b iv %b ff %b addr %h instr %h pc %h want 0/0/0/0/00000013/0",
                     imem_req_valid, instr_valid, fetch_fault, imem_addr, instr, instr_pc);
        end
        step();
        reset          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        n_vec++;
        if (instr !== 32'h0000_0013 || instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL late_rsp: instr %h iv %b req %b addr %h want 00000013/0/1/0", instr, instr_valid, imem_req_valid, imem_addr);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] a;
        bit ok;
        do_fetch(32'h0420_006F, a, ok);
        n_vec++;
        if (!ok || a !== 32'h0) begin
            n_err++;
            $display("FAIL pre_misalign: ok %0d addr %h want 1/00000000", ok, a);
        end
        retire(1'b1, 1'b0, 32'h42);
`ifdef FETCH_MISALIGN_CHK_EN
        imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                n_err++;
                $display("FAIL fault_hold_%0d: ff %b req %b iv %b want 1/0/0", i, fetch_fault, imem_req_valid, instr_valid);
            end
            step();
        end
        imem_req_ready = 1'b0;
        reset = 1'b0;
        #1;
        n_vec++;
        if (fetch_fault !== 1'b0) begin
            n_err++;
            $display("FAIL fault_clear: ff got %b want 0", fetch_fault);
        end
        step();
        reset = 1'b1;
`else
        n_vec++;
        if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1) begin
            n_err++;
            $display("FAIL no_fault: ff %b req %b want 0/1", fetch_fault, imem_req_valid);
        end
        do_fetch(32'h0000_0013, a, ok);
        n_vec++;
        if (!ok || a !== 32'h40) begin
            n_err++;
            $display("FAIL misalign_mask: ok %0d addr %h want 1/00000040", ok, a);
        end
`endif
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        reset           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rdata      = 32'h0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_jalr   = 1'b0;
        redirect_target = 32'h0;
        test_reset();
        test_first_fetch();
        test_sequential();
        test_redirect();
        test_backpressure();
        test_wrap_and_reset();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
